// File: rtl/tmds_encoder_8b10b.sv
// Single-channel DVI TMDS encoder: one 8-bit colour component plus two control bits
// become a DC-balanced 10-bit character per pixel clock, through a three-stage pipeline.
module tmds_encoder_8b10b (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] dout
);

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [7:0] din_s1;
  logic       c0_s1, c1_s1, de_s1;
  logic [3:0] n1d_s1;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      din_s1 <= '0;
      c0_s1  <= 1'b0;
      c1_s1  <= 1'b0;
      de_s1  <= 1'b0;
      n1d_s1 <= '0;
    end else begin
      din_s1 <= din;
      c0_s1  <= c0;
      c1_s1  <= c1;
      de_s1  <= de;
      n1d_s1 <= count_ones(din);
    end
  end

  // XNOR chaining is chosen for bytes heavy in ones, which keeps transitions low
  logic       use_xnor;
  logic [8:0] q_m;
  logic [3:0] n1q_next;

  always_comb begin
    use_xnor = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !din_s1[0]);
    q_m      = '0;
    q_m[0]   = din_s1[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ din_s1[i]) : (q_m[i-1] ^ din_s1[i]);
    q_m[8]   = ~use_xnor;
    n1q_next = count_ones(q_m[7:0]);
  end

  logic [8:0] q_m_s2;
  logic [3:0] n1q_s2, n0q_s2;
  logic       c0_s2, c1_s2, de_s2;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      q_m_s2 <= '0;
      n1q_s2 <= '0;
      n0q_s2 <= '0;
      c0_s2  <= 1'b0;
      c1_s2  <= 1'b0;
      de_s2  <= 1'b0;
    end else begin
      q_m_s2 <= q_m;
      n1q_s2 <= n1q_next;
      n0q_s2 <= 4'd8 - n1q_next;
      c0_s2  <= c0_s1;
      c1_s2  <= c1_s1;
      de_s2  <= de_s1;
    end
  end

  // Running disparity stays within -10..+10, so 5 signed bits never wrap
  logic signed [4:0] cnt, cnt_next;
  logic signed [4:0] n1q_w, n0q_w;
  logic        [9:0] dout_next;
  logic              qm8;

  always_comb begin
    n1q_w     = signed'({1'b0, n1q_s2});
    n0q_w     = signed'({1'b0, n0q_s2});
    qm8       = q_m_s2[8];
    dout_next = '0;
    cnt_next  = cnt;
    if (!de_s2) begin
      cnt_next = 5'sd0;
      case ({c1_s2, c0_s2})
        2'b00:   dout_next = 10'b1101010100;
        2'b01:   dout_next = 10'b0010101011;
        2'b10:   dout_next = 10'b0101010100;
        default: dout_next = 10'b1010101011;
      endcase
    end else if ((cnt == 5'sd0) || (n1q_s2 == n0q_s2)) begin
      dout_next = {~qm8, qm8, qm8 ? q_m_s2[7:0] : ~q_m_s2[7:0]};
      cnt_next  = qm8 ? (cnt + n1q_w - n0q_w) : (cnt + n0q_w - n1q_w);
    end else if (((cnt > 5'sd0) && (n1q_s2 > n0q_s2)) ||
                 ((cnt < 5'sd0) && (n0q_s2 > n1q_s2))) begin
      dout_next = {1'b1, qm8, ~q_m_s2[7:0]};
      cnt_next  = cnt + (qm8 ? 5'sd2 : 5'sd0) + n0q_w - n1q_w;
    end else begin
      dout_next = {1'b0, qm8, q_m_s2[7:0]};
      cnt_next  = cnt - (qm8 ? 5'sd0 : 5'sd2) + n1q_w - n0q_w;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dout <= '0;
      cnt  <= 5'sd0;
    end else begin
      dout <= dout_next;
      cnt  <= cnt_next;
    end
  end

endmodule
